counter_rf_regfile: RTL and testbench

- Software-accessible register file holding four free-running event counters (tsc, tsc2, tsc3, tsc4) plus a re-initialisation trigger register.
- Sits between a 64-bit word-addressed register bus and hardware logic.
- tsc and tsc4 are also hardware-loadable and hardware-visible.
- tsc2 and tsc3 are visible only through the bus.

---
 rtl/counter_rf_regfile.sv | 111 +++++++++++
 tb/tb_counter_rf_regfile.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/counter_rf_regfile.sv
// Bus-visible register file: four event counters (tsc, tsc2, tsc3, tsc4) and a write-only reinit trigger.
// Optional build macro COUNTER_RF_SATURATE_EN makes counters stick at all-ones instead of wrapping.
module counter_rf_regfile #(
    parameter int CNT_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [5:3]           address,
    output logic [63:0]          read_data,
    output logic                 invalid_address,
    output logic                 access_complete,
    input  logic                 read_en,
    input  logic                 write_en,
    input  logic [63:0]          write_data,
    input  logic [CNT_WIDTH-1:0] tsc_cnt_next,
    output logic [CNT_WIDTH-1:0] tsc_cnt,
    input  logic                 tsc_cnt_wen,
    input  logic                 tsc_cnt_countup,
    input  logic                 tsc2_cnt_countup,
    input  logic                 tsc3_cnt_countup,
    input  logic [CNT_WIDTH-1:0] tsc4_cnt_next,
    output logic [CNT_WIDTH-1:0] tsc4_cnt,
    input  logic                 tsc4_cnt_wen,
    input  logic                 tsc4_cnt_countup
);

    localparam logic [2:0] ADDR_TSC     = 3'd0;
    localparam logic [2:0] ADDR_RREINIT = 3'd1;
    localparam logic [2:0] ADDR_TSC2    = 3'd2;
    localparam logic [2:0] ADDR_TSC3    = 3'd3;
    localparam logic [2:0] ADDR_TSC4    = 3'd4;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [2:0]           word_addr;
    logic                 addr_valid;
    logic                 access;
    logic                 rreinit_q;
    logic [CNT_WIDTH-1:0] tsc_q, tsc2_q, tsc3_q, tsc4_q;
    logic [63:0]          rd_mux;

    // write_data carries no information for the trigger register
    logic unused_write_data;
    assign unused_write_data = ^write_data;

    assign word_addr  = address;
    assign addr_valid = (word_addr <= ADDR_TSC4);
    assign access     = read_en | write_en;
    assign tsc_cnt    = tsc_q;
    assign tsc4_cnt   = tsc4_q;

    function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
`ifdef COUNTER_RF_SATURATE_EN
        return (&v) ? v : v + CNT_ONE;
`else
        return v + CNT_ONE;
`endif
    endfunction

    always_comb begin
        rd_mux = '0;
        case (word_addr)
            ADDR_TSC:  rd_mux = 64'(tsc_q);
            ADDR_TSC2: rd_mux = 64'(tsc2_q);
            ADDR_TSC3: rd_mux = 64'(tsc3_q);
            ADDR_TSC4: rd_mux = 64'(tsc4_q);
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            read_data       <= '0;
            access_complete <= 1'b0;
            invalid_address <= 1'b0;
            rreinit_q       <= 1'b0;
        end else begin
            access_complete <= access;
            invalid_address <= access & ~addr_valid;
            rreinit_q       <= write_en & (word_addr == ADDR_RREINIT);
            // a write wins over a simultaneous read, so read_data only moves on pure reads
            if (access && !addr_valid)
                read_data <= '0;
            else if (read_en && !write_en)
                read_data <= rd_mux;
        end
    end

    // rreinit_q is the registered trigger, so clears land two edges after the bus write
    always_ff @(posedge clk) begin
        if (res) begin
            tsc_q  <= '0;
            tsc2_q <= '0;
            tsc3_q <= '0;
            tsc4_q <= '0;
        end else begin
            if (tsc_cnt_wen)          tsc_q <= tsc_cnt_next;
            else if (tsc_cnt_countup) tsc_q <= bump(tsc_q);

            if (rreinit_q)             tsc2_q <= '0;
            else if (tsc2_cnt_countup) tsc2_q <= bump(tsc2_q);

            if (rreinit_q)             tsc3_q <= '0;
            else if (tsc3_cnt_countup) tsc3_q <= bump(tsc3_q);

            if (rreinit_q)             tsc4_q <= '0;
            else if (tsc4_cnt_wen)     tsc4_q <= tsc4_cnt_next;
            else if (tsc4_cnt_countup) tsc4_q <= bump(tsc4_q);
        end
    end

endmodule

// File: tb/tb_counter_rf_regfile.sv
// Randomized and directed bench for counter_rf_regfile against a behavioural register-file model.
// Honours COUNTER_RF_SATURATE_EN the same way the design does.
module tb_counter_rf_regfile;

    localparam int W = 48;
    localparam logic [W-1:0] ONES = '1;

    logic          clk = 1'b0;
    logic          res;
    logic [2:0]    addr;
    logic [63:0]   read_data;
    logic          invalid_address, access_complete;
    logic          re, we;
    logic [63:0]   wd;
    logic [W-1:0]  tsc_next, tsc4_next, tsc_cnt, tsc4_cnt;
    logic          tsc_wen, tsc4_wen;
    logic [3:0]    cu;

    int n_vec = 0;
    int n_err = 0;

    counter_rf_regfile #(.CNT_WIDTH(W)) dut (
        .clk(clk), .res(res), .address(addr), .read_data(read_data),
        .invalid_address(invalid_address), .access_complete(access_complete),
        .read_en(re), .write_en(we), .write_data(wd),
        .tsc_cnt_next(tsc_next), .tsc_cnt(tsc_cnt), .tsc_cnt_wen(tsc_wen),
        .tsc_cnt_countup(cu[0]), .tsc2_cnt_countup(cu[1]), .tsc3_cnt_countup(cu[2]),
        .tsc4_cnt_next(tsc4_next), .tsc4_cnt(tsc4_cnt), .tsc4_cnt_wen(tsc4_wen),
        .tsc4_cnt_countup(cu[3])
    );

    always #5 clk = ~clk;

    // model state: counters indexed tsc, tsc2, tsc3, tsc4
    logic [W-1:0] m_cnt [4];
    bit           m_clear_pending;
    logic [63:0]  m_rd;
    bit           m_ack, m_inv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [W-1:0] inc(input logic [W-1:0] v);
`ifdef COUNTER_RF_SATURATE_EN
        if (v == ONES) return v;
`endif
        return v + 1;
    endfunction

    task automatic model_edge();
        logic [W-1:0] old [4];
        bit clr;
        bit acc;
        old = m_cnt;
        if (res === 1'b1) begin
            foreach (m_cnt[i]) m_cnt[i] = '0;
            m_clear_pending = 0;
            m_rd = '0; m_ack = 0; m_inv = 0;
        end else begin
            clr = m_clear_pending;
            m_clear_pending = (we && addr == 3'd1);
            acc = re || we;
            m_ack = acc;
            m_inv = acc && addr > 3'd4;
            if (m_inv) m_rd = '0;
            else if (re && !we) begin
                case (addr)
                    3'd0: m_rd = 64'(old[0]);
                    3'd2: m_rd = 64'(old[1]);
                    3'd3: m_rd = 64'(old[2]);
                    3'd4: m_rd = 64'(old[3]);
                    default: m_rd = '0;
                endcase
            end
            m_cnt[0] = tsc_wen ? tsc_next : (cu[0] ? inc(old[0]) : old[0]);
            m_cnt[1] = clr ? '0 : (cu[1] ? inc(old[1]) : old[1]);
            m_cnt[2] = clr ? '0 : (cu[2] ? inc(old[2]) : old[2]);
            m_cnt[3] = clr ? '0 : tsc4_wen ? tsc4_next : (cu[3] ? inc(old[3]) : old[3]);
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("tsc_cnt", 64'(tsc_cnt), 64'(m_cnt[0]));
        chk("tsc4_cnt", 64'(tsc4_cnt), 64'(m_cnt[3]));
        chk("access_complete", 64'(access_complete), 64'(m_ack));
        chk("invalid_address", 64'(invalid_address), 64'(m_inv));
        chk("read_data", read_data, m_rd);
    endtask

    task automatic idle();
        re = 0; we = 0; tsc_wen = 0; tsc4_wen = 0; cu = 4'b0; addr = 3'd0; wd = '0;
    endtask

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = '0;
        m_clear_pending = 0; m_rd = '0; m_ack = 0; m_inv = 0;
        tsc_next = '0; tsc4_next = '0;
        idle();
        @(negedge clk);

        // reset with X on the hardware controls
        res = 1; cu = 'x; tsc_wen = 'x; tsc4_wen = 'x;
        cyc();
        res = 0; idle();
        chk("reset_tsc", 64'(tsc_cnt), 64'd0);
        chk("reset_ack", 64'(access_complete), 64'd0);

        cu = 4'hF;
        repeat (199) cyc();
        chk("count199_tsc", 64'(tsc_cnt), 64'd199);
        cu = 4'h0;
        re = 1; addr = 3'd2; cyc();
        chk("read_tsc2_199", read_data, 64'd199);
        addr = 3'd3; cyc();
        chk("read_tsc3_199", read_data, 64'd199);
        re = 0; cyc();

        tsc_wen = 1; tsc4_wen = 1; tsc_next = 48'd400; tsc4_next = 48'd400;
        repeat (2) cyc();
        chk("load400_tsc4", 64'(tsc4_cnt), 64'd400);
        tsc_wen = 0; tsc4_wen = 0; cu = 4'b1001;
        repeat (199) cyc();
        chk("count599_tsc4", 64'(tsc4_cnt), 64'd599);
        cu = 4'h0;

        we = 1; addr = 3'd1; wd = {$urandom, $urandom}; cyc();
        we = 0; cyc();
        chk("reinit_tsc_kept", 64'(tsc_cnt), 64'd599);
        chk("reinit_tsc4_clr", 64'(tsc4_cnt), 64'd0);
        re = 1; addr = 3'd2; cyc();
        chk("reinit_tsc2", read_data, 64'd0);
        addr = 3'd3; cyc();
        chk("reinit_tsc3", read_data, 64'd0);

        addr = 3'd6; cyc();
        chk("unmapped_inv", 64'(invalid_address), 64'd1);
        chk("unmapped_rd", read_data, 64'd0);
        re = 0; we = 1; addr = 3'd0; wd = 64'hDEAD_BEEF; cyc();
        we = 0; cyc();
        chk("ro_write_tsc", 64'(tsc_cnt), 64'd599);

        tsc_wen = 1; tsc_next = 48'd10; cu = 4'b0001; cyc();
        chk("wen_over_countup", 64'(tsc_cnt), 64'd10);
        tsc_wen = 0; cu = 4'h0;
        tsc4_wen = 1; tsc4_next = 48'd55; cyc();
        tsc4_wen = 0; we = 1; addr = 3'd1; cyc();
        we = 0; tsc4_wen = 1; tsc4_next = 48'd77; cyc();
        chk("reinit_over_wen", 64'(tsc4_cnt), 64'd0);
        tsc4_wen = 0;

        tsc_wen = 1; tsc_next = ONES; cyc();
        tsc_wen = 0; cu = 4'b0001; cyc();
`ifdef COUNTER_RF_SATURATE_EN
        chk("ones_plus1", 64'(tsc_cnt), 64'(ONES));
`else
        chk("ones_plus1", 64'(tsc_cnt), 64'd0);
`endif
        idle();

        // random traffic; near-all-ones loads exercise the wrap/saturate edge
        for (int i = 0; i < 3000; i++) begin
            res       = ($urandom_range(0, 199) == 0);
            cu        = 4'($urandom);
            tsc_wen   = ($urandom_range(0, 15) == 0);
            tsc4_wen  = ($urandom_range(0, 15) == 0);
            tsc_next  = ($urandom_range(0, 1) == 1) ? ONES - 48'($urandom_range(0, 3)) : {16'($urandom), 32'($urandom)};
            tsc4_next = ($urandom_range(0, 1) == 1) ? ONES - 48'($urandom_range(0, 3)) : {16'($urandom), 32'($urandom)};
            re        = ($urandom_range(0, 1) == 1);
            we        = ($urandom_range(0, 4) == 0);
            addr      = 3'($urandom);
            wd        = {$urandom, $urandom};
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
